// File: rtl/shell_launcher_if.sv
`default_nettype none
// ============================================================================
//  Module   : shell_launcher_if
//  Purpose  : Bundles the shell launcher's keyboard, tank, collision and
//             shell-state signals. The master side drives keyboard, tank and
//             collision inputs; the slave side reports shell state.
//  Revision : 1.0  initial release
// ============================================================================
interface shell_launcher_if;
    logic [31:0] keycode;
    logic [9:0]  TankX;
    logic [9:0]  TankY;
    logic [7:0]  sin;
    logic [7:0]  cos;
    logic        Hit;
    logic [9:0]  ShellX;
    logic [9:0]  ShellY;
    logic [9:0]  ShellS;
    logic        ShellActive;

    modport master (
        output keycode, TankX, TankY, sin, cos, Hit,
        input  ShellX, ShellY, ShellS, ShellActive
    );

    modport slave (
        input  keycode, TankX, TankY, sin, cos, Hit,
        output ShellX, ShellY, ShellS, ShellActive
    );
endinterface
`default_nettype wire

// File: rtl/shell_launcher.sv
`default_nettype none
// ============================================================================
//  Module   : shell_launcher
//  Purpose  : Fires one shell per key press from the tank position along the
//             tank's sin/cos heading, then tracks its flight. The flight
//             ends on a hit, when its lifetime runs out, or at a wall. A
//             cooldown period follows before the launcher re-arms.
//  Options  : SHELL_BOUNCE_EN - when defined, walls reflect the shell
//             instead of ending the flight.
//  Revision : 1.0  initial release
// ============================================================================
module shell_launcher #(
    parameter logic [7:0] FIRE_KEY    = 8'h2C,
    parameter logic [6:0] SHELL_SPEED = 7'd8,
    parameter logic [7:0] LIFETIME    = 8'd255,
    parameter logic [7:0] COOLDOWN    = 8'd30,
    parameter int         X_MIN       = 0,
    parameter int         X_MAX       = 639,
    parameter int         Y_MIN       = 0,
    parameter int         Y_MAX       = 479,
    parameter logic [9:0] SHELL_SIZE  = 10'd4
) (
    input  logic             frame_clk,
    input  logic             Reset,
    shell_launcher_if.slave  bus
);

    // Play-field limits for the shell's top-left corner, in 11-bit signed form
    localparam logic signed [10:0] c_x_lo = 11'(X_MIN);
    localparam logic signed [10:0] c_x_hi = 11'(X_MAX - int'(SHELL_SIZE));
    localparam logic signed [10:0] c_y_lo = 11'(Y_MIN);
    localparam logic signed [10:0] c_y_hi = 11'(Y_MAX - int'(SHELL_SIZE));

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FLIGHT = 2'd1,
        S_COOL   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_fire_prev;
    logic        r_active;
    logic [9:0]  r_shell_x;
    logic [9:0]  r_shell_y;
    logic [9:0]  r_vel_x;
    logic [9:0]  r_vel_y;
    logic [7:0]  r_life;
    logic [7:0]  r_cnt;

    logic        w_fire_now;
    logic        w_fire_edge;
    logic [6:0]  w_mag_x;
    logic [6:0]  w_mag_y;
    logic [9:0]  w_vel_x_init;
    logic [9:0]  w_vel_y_init;
    logic signed [10:0] w_nx;
    logic signed [10:0] w_ny;
    logic        w_x_lo;
    logic        w_x_hi;
    logic        w_y_lo;
    logic        w_y_hi;
    logic        w_wall_term;
    logic        w_terminate;

    // Any of the four reported keys matching the fire key counts as pressed
    assign w_fire_now  = (bus.keycode[7:0]   == FIRE_KEY) |
                         (bus.keycode[15:8]  == FIRE_KEY) |
                         (bus.keycode[23:16] == FIRE_KEY) |
                         (bus.keycode[31:24] == FIRE_KEY);
    assign w_fire_edge = w_fire_now & ~r_fire_prev;

    // Speed-scaled magnitudes; the top 7 bits of the 14-bit product
    assign w_mag_x = 7'((14'(SHELL_SPEED) * 14'(bus.cos[6:0])) >> 7);
    assign w_mag_y = 7'((14'(SHELL_SPEED) * 14'(bus.sin[6:0])) >> 7);

    // Screen Y grows downward, so a positive sine moves the shell up
    assign w_vel_x_init = bus.cos[7] ? (10'd0 - {3'b000, w_mag_x}) : {3'b000, w_mag_x};
    assign w_vel_y_init = bus.sin[7] ? {3'b000, w_mag_y} : (10'd0 - {3'b000, w_mag_y});

    // Candidate next position; one extra bit keeps underflow visible
    assign w_nx = $signed({1'b0, r_shell_x}) + $signed({r_vel_x[9], r_vel_x});
    assign w_ny = $signed({1'b0, r_shell_y}) + $signed({r_vel_y[9], r_vel_y});

    assign w_x_lo = (w_nx < c_x_lo);
    assign w_x_hi = (w_nx > c_x_hi);
    assign w_y_lo = (w_ny < c_y_lo);
    assign w_y_hi = (w_ny > c_y_hi);

`ifdef SHELL_BOUNCE_EN
    assign w_wall_term = 1'b0;
`else
    assign w_wall_term = w_x_lo | w_x_hi | w_y_lo | w_y_hi;
`endif

    // Hit and expiry in the same frame collapse into one termination
    assign w_terminate = bus.Hit | (r_life == 8'd1) | w_wall_term;

    // Launcher state machine with fire-edge history and shell kinematics
    always_ff @(posedge frame_clk) begin
        if (!Reset) begin
            r_state     <= S_IDLE;
            r_fire_prev <= 1'b1;
            r_active    <= 1'b0;
            r_shell_x   <= 10'd0;
            r_shell_y   <= 10'd0;
            r_vel_x     <= 10'd0;
            r_vel_y     <= 10'd0;
            r_life      <= 8'd0;
            r_cnt       <= 8'd0;
        end else begin
            r_fire_prev <= w_fire_now;
            case (r_state)
                S_IDLE: begin
                    if (w_fire_edge) begin
                        r_state   <= S_FLIGHT;
                        r_active  <= 1'b1;
                        r_shell_x <= bus.TankX;
                        r_shell_y <= bus.TankY;
                        r_life    <= LIFETIME;
                        r_vel_x   <= w_vel_x_init;
                        r_vel_y   <= w_vel_y_init;
                    end
                end
                S_FLIGHT: begin
                    if (w_terminate) begin
                        // Position is left as-is on the terminating frame
                        r_state  <= S_COOL;
                        r_active <= 1'b0;
                        r_cnt    <= COOLDOWN;
                    end else begin
                        r_life <= r_life - 8'd1;
`ifdef SHELL_BOUNCE_EN
                        if (w_x_lo) begin
                            r_shell_x <= c_x_lo[9:0];
                            r_vel_x   <= 10'd0 - r_vel_x;
                        end else if (w_x_hi) begin
                            r_shell_x <= c_x_hi[9:0];
                            r_vel_x   <= 10'd0 - r_vel_x;
                        end else begin
                            r_shell_x <= w_nx[9:0];
                        end
                        if (w_y_lo) begin
                            r_shell_y <= c_y_lo[9:0];
                            r_vel_y   <= 10'd0 - r_vel_y;
                        end else if (w_y_hi) begin
                            r_shell_y <= c_y_hi[9:0];
                            r_vel_y   <= 10'd0 - r_vel_y;
                        end else begin
                            r_shell_y <= w_ny[9:0];
                        end
`else
                        r_shell_x <= w_nx[9:0];
                        r_shell_y <= w_ny[9:0];
`endif
                    end
                end
                S_COOL: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ShellX      = r_shell_x;
    assign bus.ShellY      = r_shell_y;
    assign bus.ShellS      = SHELL_SIZE;
    assign bus.ShellActive = r_active;

endmodule
`default_nettype wire

// File: doc/shell_launcher.md
SHELL_LAUNCHER -- requirements
Module: shell_launcher

Interface
- REQ-001 Parameters SHALL be:
  - FIRE_KEY, 8'h2C, USB keycode that fires.
  - SHELL_SPEED, 7'd8, scale applied to sin/cos magnitude.
  - LIFETIME, 8'd255, flight duration in frames.
  - COOLDOWN, 8'd30, frames after termination before re-arm.
  - X_MIN / X_MAX, 0 / 639, horizontal play-field bounds.
  - Y_MIN / Y_MAX, 0 / 479, vertical play-field bounds.
  - SHELL_SIZE, 10'd4, shell width/height.
- REQ-002 Ports SHALL be (name, direction, width, meaning):
  - frame_clk, in, 1, sole clock.
  - Reset, in, 1, synchronous active-low reset.
  - keycode, in, 32, four packed USB keycodes.
  - TankX / TankY, in, 10 each, launching tank position.
  - sin / cos, in, 8 each, sign-magnitude (bit7 sign, [6:0] magnitude) for the tank's current angle.
  - Hit, in, 1, collision logic reports that the shell struck something.
  - ShellX / ShellY, out, 10 each, shell position.
  - ShellS, out, 10, shell size.
  - ShellActive, out, 1, shell is in flight.
- REQ-003 The block SHALL have one clock, frame_clk; the reset Reset SHALL be synchronous and active-low.

Function
- REQ-004 fire_now SHALL be 1 when any keycode byte equals FIRE_KEY.
- REQ-005 fire_prev SHALL register fire_now every frame.
- REQ-006 fire_edge SHALL be fire_now & ~fire_prev; a held key SHALL fire only once.
- REQ-007 The FSM SHALL have exactly three states: IDLE, FLIGHT and COOL.
- REQ-008 In IDLE with fire_edge=1, the next edge SHALL:
  - enter FLIGHT with ShellActive=1;
  - load ShellX=TankX and ShellY=TankY;
  - load life=LIFETIME;
  - latch VelX and VelY from the sin/cos values sampled that same cycle.
- REQ-009 Velocity arithmetic:
  - magX = (SHELL_SPEED*cos[6:0])[13:7] and magY = (SHELL_SPEED*sin[6:0])[13:7].
  - VelX = cos[7] ? -magX : +magX.
  - VelY = sin[7] ? +magY : -magY, since screen Y grows downward.
  - Both SHALL be 10-bit two's complement.
- REQ-010 In FLIGHT, each edge SHALL compute ShellX+VelX and ShellY+VelY in 11-bit signed arithmetic, then apply wall handling and decrement life.
- REQ-011 A wall violation SHALL be next X < X_MIN, next X > X_MAX-SHELL_SIZE, or the equivalent for Y; X and Y SHALL be evaluated independently in the same frame.
- REQ-012 From FLIGHT, the block SHALL enter COOL with ShellActive=0 on the edge where any of these holds: Hit=1, life equals 1, or a terminating wall violation (see REQ-018).
- REQ-013 When Hit and expiry coincide, the block SHALL take one COOL transition and SHALL load the cooldown counter once.
- REQ-014 COOL SHALL load cnt=COOLDOWN and decrement it each frame; the block SHALL return to IDLE on the edge after cnt reaches 0.
- REQ-015 fire_edge in FLIGHT or COOL SHALL be ignored and not queued.
- REQ-016 Hit SHALL be ignored outside FLIGHT.
- REQ-017 ShellS SHALL always equal SHELL_SIZE; ShellX and ShellY SHALL hold their last values while inactive.

Configuration
- REQ-018 Macro SHELL_BOUNCE_EN:
  - Defined: an X violation SHALL clamp ShellX to the violated bound and set VelX=-VelX (Y likewise), and flight SHALL continue.
  - Undefined: any wall violation SHALL terminate the flight as in REQ-012 and SHALL leave the position unchanged that frame.

Reset
- REQ-019 Reset=0 sampled on an edge SHALL force IDLE and clear ShellActive, ShellX, ShellY, VelX, VelY, life and cnt to 0.
- REQ-020 Reset SHALL set fire_prev=1, so a key held through reset release does not fire.
- REQ-021 Reset mid-FLIGHT or mid-COOL SHALL take effect on that same edge.

Verification
- REQ-022 Tank at (300,250), cos=8'h7F, sin=8'h00, press FIRE_KEY one frame -> ShellActive=1 at (300,250); next frames ShellX=307, 314, 321 with ShellY=250.
- REQ-023 Hold FIRE_KEY for 600 frames with LIFETIME=255 and COOLDOWN=30 -> exactly one flight; no refire after COOL ends until release then re-press.
- REQ-024 With SHELL_BOUNCE_EN, ShellX=633 and VelX=+7 -> ShellX=635 and VelX=-7; then 628. Without the macro -> ShellActive=0 and COOL entered.
- REQ-025 Hit=1 on the same frame that life=1 -> single COOL entry; cnt=30; IDLE reached exactly 31 frames later.
- REQ-026 Reset=0 asserted mid-FLIGHT while FIRE_KEY is held, then released -> outputs 0 and state IDLE the same edge; no fire until the key is re-pressed.
